// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and limits for the DMA channel arbiter slice.
//   DMA_MAX_CH   largest channel count the arbiter is built for
//   arb_state_e  states of the HRQ/HLDA handshake engine
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam int DMA_MAX_CH = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,     // no hold requested
    ARB_REQ,      // HRQ raised, waiting for HLDA
    ARB_GRANT,    // bus held, one channel acknowledged
    ARB_RELEASE   // HRQ dropped, waiting for the CPU to drop HLDA
  } arb_state_e;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// -----------------------------------------------------------------------------
// dma_priority_arbiter_if
// Request/acknowledge bundle between the channel pins, the CPU hold handshake,
// timing control and the arbiter.
//   master : drives requests, configuration, HLDA and XFER_DONE
//   slave  : the arbiter; drives HRQ, DACK, ACT_CH and ACT_VALID
// -----------------------------------------------------------------------------
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] dreq;             // raw channel requests
  logic [NUM_CH-1:0] dreq_mask;        // 1 = channel ignored for new picks
  logic              rot_prio;         // 0 = fixed (ch0 highest), 1 = rotating
  logic              dreq_sense_low;   // 1 = DREQ pins are active-low
  logic              dack_sense_high;  // 1 = DACK pins are active-high
  logic              ctrl_disable;     // 1 = no new HRQ
  logic              hlda;             // hold acknowledge from CPU
  logic              xfer_done;        // service of granted channel ended
  logic              hrq;              // hold request to CPU
  logic [NUM_CH-1:0] dack;             // one-hot acknowledge, pin polarity
  logic [CH_W-1:0]   act_ch;           // granted channel index
  logic              act_valid;        // a channel is granted

  modport master (
    output dreq, dreq_mask, rot_prio, dreq_sense_low, dack_sense_high,
           ctrl_disable, hlda, xfer_done,
    input  hrq, dack, act_ch, act_valid
  );

  modport slave (
    input  dreq, dreq_mask, rot_prio, dreq_sense_low, dack_sense_high,
           ctrl_disable, hlda, xfer_done,
    output hrq, dack, act_ch, act_valid
  );

endinterface

// File: rtl/dma_prio_pick.sv
// -----------------------------------------------------------------------------
// dma_prio_pick
// Combinational rotating priority search. Starting at index `top` and walking
// upward modulo NUM_CH, the first set request bit wins.
//   req    in   NUM_CH  effective (polarity-corrected, unmasked) requests
//   top    in   CH_W    highest-priority index for this search
//   hit    out  1       at least one request present
//   idx    out  CH_W    winning channel index (0 when !hit)
//   onehot out  NUM_CH  winning channel as a one-hot vector (0 when !hit)
// -----------------------------------------------------------------------------
module dma_prio_pick #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   top,
  output logic              hit,
  output logic [CH_W-1:0]   idx,
  output logic [NUM_CH-1:0] onehot
);

  // One extra bit so top + offset can exceed NUM_CH before wrapping.
  logic [CH_W:0] pos;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise paths that skip the assignment hold the
  // old value and a latch is inferred.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos = {1'b0, top} + (CH_W+1)'(i);
      if (pos >= (CH_W+1)'(NUM_CH)) begin
        pos = pos - (CH_W+1)'(NUM_CH);
      end
      if (!hit && req[pos[CH_W-1:0]]) begin
        hit                   = 1'b1;
        idx                   = pos[CH_W-1:0];
        onehot[pos[CH_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// -----------------------------------------------------------------------------
// dma_priority_arbiter
// DMA channel arbiter and HRQ/HLDA bus-handshake engine for NUM_CH channels
// (2..DMA_MAX_CH). A channel request raises HRQ; once the CPU answers with
// HLDA the highest-priority pending channel is latched as a one-hot grant
// that drives DACK and selects that channel's address/count registers.
//   clk   in  1      system clock, all state on the rising edge
//   rst   in  1      asynchronous, active-high reset
//   bus   slave      dma_priority_arbiter_if: requests, mask, priority mode,
//                    pin polarities, HLDA, XFER_DONE in; HRQ, DACK, ACT_CH,
//                    ACT_VALID out
// -----------------------------------------------------------------------------
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input logic                  clk,
  input logic                  rst,
  dma_priority_arbiter_if.slave bus
);

  localparam int CH_W = $clog2(NUM_CH);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CH_W-1:0]   act_ch_q, act_ch_d;
  logic [CH_W-1:0]   top_q, top_d;

  logic [NUM_CH-1:0] req_eff;
  logic              req_any;
  logic [CH_W-1:0]   pick_top;
  logic              pick_hit;
  logic [CH_W-1:0]   pick_idx;
  logic [NUM_CH-1:0] pick_onehot;
  logic [CH_W-1:0]   top_after;

  // Requests as seen by arbitration: pin polarity removed, masked channels out.
  assign req_eff = (bus.dreq ^ {NUM_CH{bus.dreq_sense_low}}) & ~bus.dreq_mask;
  assign req_any = |req_eff;

  // Fixed priority is simply a rotating search that always starts at ch0, so
  // flipping rot_prio takes effect on the very next pick.
  assign pick_top = bus.rot_prio ? top_q : '0;

  dma_prio_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req    (req_eff),
    .top    (pick_top),
    .hit    (pick_hit),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // The channel just serviced becomes lowest priority.
  assign top_after = (act_ch_q == CH_W'(NUM_CH - 1)) ? '0 : act_ch_q + CH_W'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    act_ch_d = act_ch_q;
    top_d    = top_q;
    case (state_q)
      ARB_IDLE: begin
        if (req_any && !bus.ctrl_disable && !bus.hlda) begin
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (bus.hlda && pick_hit) begin
          state_d  = ARB_GRANT;
          grant_d  = pick_onehot;
          act_ch_d = pick_idx;
        end else if (!req_any) begin
          // Request withdrawn before the bus was handed over.
          state_d = ARB_RELEASE;
        end
      end
      ARB_GRANT: begin
        // Once granted, request/mask changes are ignored; only completion or
        // a CPU revoke ends the grant. Completion wins if both coincide.
        if (bus.xfer_done) begin
          state_d = ARB_RELEASE;
          grant_d = '0;
          top_d   = top_after;
        end else if (!bus.hlda) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      ARB_RELEASE: begin
        if (!bus.hlda) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      act_ch_q <= '0;
      top_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      act_ch_q <= act_ch_d;
      top_q    <= top_d;
    end
  end

  // Decoded straight from the registered state, so the async reset drops
  // HRQ and ACT_VALID without waiting for a clock edge.
  assign bus.hrq       = (state_q == ARB_REQ) || (state_q == ARB_GRANT);
  assign bus.act_valid = (state_q == ARB_GRANT);
  assign bus.act_ch    = act_ch_q;
  assign bus.dack      = bus.dack_sense_high ? grant_q : ~grant_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_priority_arbiter
// Drives a 4-channel and an 8-channel arbiter from one shared stimulus set
// (the 4-channel instance sees the low four bits) and compares both against a
// cycle-level behavioural model of the hold handshake and priority rules.
// -----------------------------------------------------------------------------
module tb_dma_priority_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] dreq_v, mask_v;
  logic       rot_v, sense_low_v, dack_high_v, cdis_v, hlda_v, xdone_v;

  int checks = 0;
  int errors = 0;

  dma_priority_arbiter_if #(.NUM_CH(4)) bus4 ();
  dma_priority_arbiter_if #(.NUM_CH(8)) bus8 ();

  assign bus4.dreq            = dreq_v[3:0];
  assign bus4.dreq_mask       = mask_v[3:0];
  assign bus4.rot_prio        = rot_v;
  assign bus4.dreq_sense_low  = sense_low_v;
  assign bus4.dack_sense_high = dack_high_v;
  assign bus4.ctrl_disable    = cdis_v;
  assign bus4.hlda            = hlda_v;
  assign bus4.xfer_done       = xdone_v;

  assign bus8.dreq            = dreq_v;
  assign bus8.dreq_mask       = mask_v;
  assign bus8.rot_prio        = rot_v;
  assign bus8.dreq_sense_low  = sense_low_v;
  assign bus8.dack_sense_high = dack_high_v;
  assign bus8.ctrl_disable    = cdis_v;
  assign bus8.hlda            = hlda_v;
  assign bus8.xfer_done       = xdone_v;

  dma_priority_arbiter #(.NUM_CH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  dma_priority_arbiter #(.NUM_CH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = 4 ch, 1 = 8 ch) -------------
  int m_n[2] = '{4, 8};
  int m_gch[2];       // granted channel, -1 = none
  int m_top[2];       // first channel searched under rotating priority
  bit m_hrq[2];       // hold requested
  bit m_wait_low[2];  // bus given back, waiting for HLDA to fall

  function automatic int eff_req(input int d);
    int r = 0;
    for (int c = 0; c < m_n[d]; c++)
      if (((dreq_v[c] ^ sense_low_v) == 1'b1) && !mask_v[c]) r |= (1 << c);
    return r;
  endfunction

  function automatic int pick(input int d, input int r, input int start);
    for (int i = 0; i < m_n[d]; i++) begin
      int c = (start + i) % m_n[d];
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_gch[d] = -1; m_top[d] = 0; m_hrq[d] = 0; m_wait_low[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    int r = eff_req(d);
    if (m_gch[d] >= 0) begin
      if (xdone_v) begin
        m_top[d] = (m_gch[d] + 1) % m_n[d];
        m_gch[d] = -1; m_hrq[d] = 0; m_wait_low[d] = 1;
      end else if (!hlda_v) begin
        m_gch[d] = -1; m_hrq[d] = 0;
      end
    end else if (m_hrq[d]) begin
      if (hlda_v && r != 0) m_gch[d] = pick(d, r, rot_v ? m_top[d] : 0);
      else if (r == 0) begin m_hrq[d] = 0; m_wait_low[d] = 1; end
    end else if (m_wait_low[d]) begin
      if (!hlda_v) m_wait_low[d] = 0;
    end else if (r != 0 && !cdis_v && !hlda_v) begin
      m_hrq[d] = 1;
    end
  endtask

  task automatic compare(input int d, input string nm, input logic hrq,
                         input logic [7:0] dack, input logic [2:0] ch, input logic valid);
    int oh   = (m_gch[d] >= 0) ? (1 << m_gch[d]) : 0;
    int full = (1 << m_n[d]) - 1;
    int dexp = dack_high_v ? oh : (~oh & full);
    check({nm, ".hrq"}, {31'd0, hrq}, {31'd0, m_hrq[d]});
    check({nm, ".dack"}, {24'd0, dack}, dexp);
    check({nm, ".valid"}, {31'd0, valid}, (m_gch[d] >= 0) ? 1 : 0);
    if (m_gch[d] >= 0) check({nm, ".ch"}, {29'd0, ch}, m_gch[d]);
  endtask

  task automatic compare_all();
    compare(0, "n4", bus4.hrq, 8'(bus4.dack), 3'(bus4.act_ch), bus4.act_valid);
    compare(1, "n8", bus8.hrq, bus8.dack, bus8.act_ch, bus8.act_valid);
  endtask

  // Inputs are stable across the edge; the model consumes them at posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
    compare_all();
  endtask

  task automatic set_defaults();
    dreq_v = '0; mask_v = '0; rot_v = 0; sense_low_v = 0; dack_high_v = 1;
    cdis_v = 0; hlda_v = 0; xdone_v = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".hrq4"}, {31'd0, bus4.hrq}, 0);
    check({tag, ".valid8"}, {31'd0, bus8.act_valid}, 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_hrq(input string tag);
    int k = 0;
    while (!(bus4.hrq && bus8.hrq) && k < 20) begin
      step();
      k++;
    end
    check({tag, ".hrq_wait"}, {31'd0, bus4.hrq && bus8.hrq}, 1);
  endtask

  initial begin
    set_defaults();
    do_reset();

    // 1: fixed priority, HLDA two cycles after HRQ.
    dreq_v = 8'b1010;
    step();
    check("t1.hrq", {31'd0, bus4.hrq}, 1);
    step(); step();
    hlda_v = 1; step();
    check("t1.dack4", {28'd0, bus4.dack}, 4'b0010);
    check("t1.dack8", {24'd0, bus8.dack}, 8'b0000_0010);
    check("t1.ch", {30'd0, bus4.act_ch}, 1);
    xdone_v = 1; step();
    xdone_v = 0; hlda_v = 0; dreq_v = 8'b1000; step();
    step();
    hlda_v = 1; step();
    check("t1.ch3", {30'd0, bus4.act_ch}, 3);
    check("t1.dack4b", {28'd0, bus4.dack}, 4'b1000);
    xdone_v = 1; step();
    xdone_v = 0; hlda_v = 0; dreq_v = 0; step();

    // 2: rotating priority, all channels requesting.
    do_reset();
    rot_v = 1; dreq_v = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      hlda_v = 0;
      wait_hrq("t2");
      hlda_v = 1; step();
      check("t2.rot4", {30'd0, bus4.act_ch}, i % 4);
      check("t2.rot8", {29'd0, bus8.act_ch}, i);
      xdone_v = 1; step();
      xdone_v = 0; hlda_v = 0; step();
    end
    dreq_v = 0; step(); step();

    // 3: request withdrawn before HLDA.
    do_reset();
    dreq_v = 8'b0100; step();
    dreq_v = 0; step();
    check("t3.hrq_drop", {31'd0, bus4.hrq}, 0);
    hlda_v = 1; step(); step();
    check("t3.no_dack", {28'd0, bus4.dack}, 0);
    dreq_v = 8'b0100; step();
    check("t3.hold_off", {31'd0, bus4.hrq}, 0);
    hlda_v = 0; step(); step();
    check("t3.rereq", {31'd0, bus4.hrq}, 1);
    dreq_v = 0; step(); step();

    // 4: CPU revoke keeps the pointer.
    do_reset();
    rot_v = 1; dreq_v = 8'b0001;
    wait_hrq("t4a");
    hlda_v = 1; step();
    xdone_v = 1; step();
    xdone_v = 0; hlda_v = 0; dreq_v = 8'b0011; step();
    wait_hrq("t4b");
    hlda_v = 1; step();
    check("t4.ch1", {30'd0, bus4.act_ch}, 1);
    hlda_v = 0; step();
    check("t4.revoke", {31'd0, bus4.act_valid}, 0);
    wait_hrq("t4c");
    hlda_v = 1; step();
    check("t4.again", {30'd0, bus4.act_ch}, 1);
    check("t4.again8", {29'd0, bus8.act_ch}, 1);
    xdone_v = 1; step();
    xdone_v = 0; hlda_v = 0; dreq_v = 0; step(); step();

    // 5: active-low DREQ and DACK with masking.
    set_defaults();
    do_reset();
    sense_low_v = 1; dack_high_v = 0; dreq_v = 8'hFD; mask_v = 8'h02;
    step(); step(); step();
    check("t5.masked", {31'd0, bus4.hrq}, 0);
    mask_v = 0;
    wait_hrq("t5");
    hlda_v = 1; step();
    check("t5.dack4", {28'd0, bus4.dack}, 4'b1101);
    check("t5.dack8", {24'd0, bus8.dack}, 8'hFD);

    // 6: asynchronous reset in the middle of a grant.
    mid_reset("t6");
    check("t6.dack4", {28'd0, bus4.dack}, 4'b1111);
    set_defaults();
    step();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      dreq_v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      mask_v = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 19) == 0) rot_v = ~rot_v;
      if ($urandom_range(0, 49) == 0) sense_low_v = ~sense_low_v;
      if ($urandom_range(0, 19) == 0) dack_high_v = ~dack_high_v;
      cdis_v  = ($urandom_range(0, 9) == 0);
      hlda_v  = m_hrq[0] ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 25);
      xdone_v = ($urandom_range(0, 4) == 0);
      step();
      if ($urandom_range(0, 199) == 0) mid_reset("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
